// File: rtl/rose_burst_responder.sv
// Purpose : watches req for a rising edge, then emits pulse_cnt single-cycle ack
//           pulses, each preceded by max(gap_len,1) low cycles; done follows the
//           last ack. Latency: first ack g_eff cycles after the sampled rise.
//           Backpressure: none; a rise while busy is ignored and flagged on drop.
// Ports   : clk, rst_n (async active-low), req (level, rise-triggered),
//           pulse_cnt/gap_len (sampled on the accepted rise),
//           ack, busy, done, err (illegal count), drop (rise while busy).
module rose_burst_responder #(
  parameter int MAX_PULSES = 3,
  parameter int CNT_W      = 2,
  parameter int GAP_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic [CNT_W-1:0] pulse_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             ack,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             drop
);

  typedef enum logic [1:0] {IDLE, WAIT, PULSE, DONE} state_t;

  localparam logic [CNT_W:0]   MAX_CNT = MAX_PULSES[CNT_W:0];
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
  localparam logic [GAP_W-1:0] ONE_GAP = GAP_W'(1);

  state_t           state, state_nxt;
  logic             req_q;
  logic [GAP_W-1:0] timer, timer_nxt;
  logic [GAP_W-1:0] gap_q, gap_nxt;
  logic [CNT_W-1:0] remaining, remaining_nxt;
  logic             ack_nxt, busy_nxt, done_nxt, err_nxt, drop_nxt;

  logic             rise;
  logic             cnt_ok;
  logic [GAP_W-1:0] g_in;

  // req_q resets low, so a req already high at the first edge counts as a rise.
  assign rise   = req & ~req_q;
  assign cnt_ok = (pulse_cnt != '0) && ({1'b0, pulse_cnt} <= MAX_CNT);
  // A zero gap is promoted to one so acks can never be back-to-back.
  assign g_in   = (gap_len == '0) ? ONE_GAP : gap_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      req_q     <= 1'b0;
      timer     <= '0;
      gap_q     <= '0;
      remaining <= '0;
      ack       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      drop      <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_q     <= req;
      timer     <= timer_nxt;
      gap_q     <= gap_nxt;
      remaining <= remaining_nxt;
      ack       <= ack_nxt;
      busy      <= busy_nxt;
      done      <= done_nxt;
      err       <= err_nxt;
      drop      <= drop_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    gap_nxt       = gap_q;
    remaining_nxt = remaining;
    ack_nxt       = 1'b0;
    done_nxt      = 1'b0;
    err_nxt       = 1'b0;
    drop_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          if (cnt_ok) begin
            remaining_nxt = pulse_cnt;
            gap_nxt       = g_in;
            timer_nxt     = g_in - ONE_GAP;
            state_nxt     = WAIT;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      WAIT: begin
        drop_nxt = rise;
        if (timer == '0) begin
          ack_nxt   = 1'b1;
          state_nxt = PULSE;
        end else begin
          timer_nxt = timer - ONE_GAP;
        end
      end
      PULSE: begin
        drop_nxt      = rise;
        remaining_nxt = remaining - ONE_CNT;
        if (remaining == ONE_CNT) begin
          done_nxt  = 1'b1;
          state_nxt = DONE;
        end else begin
          // Reload so the next ack again sees exactly g_eff low cycles.
          timer_nxt = gap_q - ONE_GAP;
          state_nxt = WAIT;
        end
      end
      DONE: begin
        drop_nxt  = rise;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy is registered alongside the state it describes.
  assign busy_nxt = (state_nxt != IDLE);

endmodule

// File: tb/tb_rose_burst_responder.sv
module tb_rose_burst_responder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [1:0] pulse_cnt;
  logic [3:0] gap_len;
  logic       ack, busy, done, err, drop;

  rose_burst_responder #(.MAX_PULSES(3), .CNT_W(2), .GAP_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .pulse_cnt (pulse_cnt),
    .gap_len   (gap_len),
    .ack       (ack),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  // Output vector order: {busy, ack, done, err, drop}
  localparam logic [4:0] V_IDLE  = 5'b00000;
  localparam logic [4:0] V_BUSY  = 5'b10000;
  localparam logic [4:0] V_ACK   = 5'b11000;
  localparam logic [4:0] V_DONE  = 5'b10100;
  localparam logic [4:0] V_ERR   = 5'b00010;
  localparam logic [4:0] V_ACKDR = 5'b11001;

  typedef struct {
    int         cyc;
    logic [4:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic busy_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Insert keeping the queue ordered by cycle.
  task automatic push(input int c, input logic [4:0] v, input string name);
    exp_t e;
    int   i;
    e.cyc = c; e.v = v; e.name = name;
    i = 0;
    while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
    exp_q.insert(i, e);
  endtask

  task automatic check1(input string name, input logic got, input logic want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, got, want);
    end
  endtask

  task automatic issue(input logic [1:0] n, input logic [3:0] g, output int e0);
    @(negedge clk);
    pulse_cnt = n;
    gap_len   = g;
    req       = 1'b1;
    e0        = cyc + 1;
  endtask

  // Monitor: any pulse output or a busy transition is an event to be matched.
  always @(negedge clk) begin
    logic [4:0] outv;
    exp_t       e;
    outv = {busy, ack, done, err, drop};
    if (outv[3:0] != 4'b0000 || busy != busy_prev) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected: cycle %0d outputs busy/ack/done/err/drop=%b, none expected",
                 cyc, outv);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.v !== outv) begin
          n_fail++;
          $display("FAIL %s: got %b at cycle %0d, expected %b at cycle %0d",
                   e.name, outv, cyc, e.v, e.cyc);
        end
      end
    end
    busy_prev = busy;
  end

  initial begin
    int e0, e1;
    rst_n = 1'b0; req = 1'b0; pulse_cnt = '0; gap_len = '0;
    repeat (3) @(negedge clk);
    check1("reset ack",  ack,  1'b0);
    check1("reset busy", busy, 1'b0);
    check1("reset done", done, 1'b0);
    check1("reset err",  err,  1'b0);
    check1("reset drop", drop, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic N=3, gap 1: acks at E0+1,+3,+5; done +6; idle +7
    issue(2'd3, 4'd1, e0);
    push(e0 + 0, V_BUSY, "t1 busy rise");
    push(e0 + 1, V_ACK,  "t1 ack1");
    push(e0 + 3, V_ACK,  "t1 ack2");
    push(e0 + 5, V_ACK,  "t1 ack3");
    push(e0 + 6, V_DONE, "t1 done");
    push(e0 + 7, V_IDLE, "t1 busy fall");
    @(negedge clk) req = 1'b0;
    repeat (10) @(negedge clk);

    // Single pulse, gap 5; inputs change after the accepted rise
    issue(2'd1, 4'd5, e0);
    push(e0 + 0, V_BUSY, "t2 busy rise");
    push(e0 + 5, V_ACK,  "t2 ack");
    push(e0 + 6, V_DONE, "t2 done");
    push(e0 + 7, V_IDLE, "t2 busy fall");
    @(negedge clk);
    req = 1'b0; pulse_cnt = 2'd3; gap_len = 4'd0;
    repeat (10) @(negedge clk);

    // Illegal count
    issue(2'd0, 4'd2, e0);
    push(e0 + 0, V_ERR, "t3 err");
    @(negedge clk) req = 1'b0;
    repeat (6) @(negedge clk);

    // gap 0 -> 1, second rise lands in WAIT together with the second ack
    issue(2'd2, 4'd0, e0);
    push(e0 + 0, V_BUSY,  "t4 busy rise");
    push(e0 + 1, V_ACK,   "t4 ack1");
    push(e0 + 3, V_ACKDR, "t4 ack2+drop");
    push(e0 + 4, V_DONE,  "t4 done");
    push(e0 + 5, V_IDLE,  "t4 busy fall");
    @(negedge clk) req = 1'b0;
    @(negedge clk);
    @(negedge clk) req = 1'b1;
    @(negedge clk) req = 1'b0;
    repeat (8) @(negedge clk);

    // Reset after first ack; req held high so release gives a fresh rise
    issue(2'd3, 4'd2, e0);
    push(e0 + 0, V_BUSY, "t5 busy rise");
    push(e0 + 2, V_ACK,  "t5 ack1");
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check1("t5 async ack",  ack,  1'b0);
    check1("t5 async busy", busy, 1'b0);
    check1("t5 async done", done, 1'b0);
    push(e0 + 3, V_IDLE, "t5 reset idle");
    repeat (2) @(negedge clk);
    pulse_cnt = 2'd2; gap_len = 4'd3;
    #1 rst_n = 1'b1;
    e1 = cyc + 1;
    push(e1 + 0, V_BUSY, "t5 restart busy");
    push(e1 + 3, V_ACK,  "t5 restart ack1");
    push(e1 + 7, V_ACK,  "t5 restart ack2");
    push(e1 + 8, V_DONE, "t5 restart done");
    push(e1 + 9, V_IDLE, "t5 restart fall");
    @(negedge clk) req = 1'b0;
    repeat (12) @(negedge clk);

    // Back-to-back: second rise sampled one cycle after busy falls
    issue(2'd1, 4'd2, e0);
    push(e0 + 0, V_BUSY, "t6a busy rise");
    push(e0 + 2, V_ACK,  "t6a ack");
    push(e0 + 3, V_DONE, "t6a done");
    push(e0 + 4, V_IDLE, "t6a busy fall");
    @(negedge clk) req = 1'b0;
    repeat (4) @(negedge clk);
    pulse_cnt = 2'd2; gap_len = 4'd1; req = 1'b1;
    e1 = cyc + 1;
    push(e1 + 0, V_BUSY, "t6b busy rise");
    push(e1 + 1, V_ACK,  "t6b ack1");
    push(e1 + 3, V_ACK,  "t6b ack2");
    push(e1 + 4, V_DONE, "t6b done");
    push(e1 + 5, V_IDLE, "t6b busy fall");
    @(negedge clk);
    req = 1'b0; pulse_cnt = 2'd0; gap_len = 4'd9;
    repeat (10) @(negedge clk);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected events never seen, expected 0 (first %s)",
               exp_q.size(), exp_q[0].name);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rose_burst_responder.md
Name: rose_burst_responder

Overview:
- Synthesizable responder for the request/acknowledge handshake whose checker side is `$rose(req) |-> strong(ack[->MIN:MAX])`.
- Watches `req` for a rising edge, then emits a programmed number of single-cycle `ack` pulses. Pulses are never back-to-back; each is separated by a programmed number of low cycles.
- Drives the `b`-side stimulus for the team's repetition-operator assertion benches, and serves as a stub responder in small handshake designs.

Parameters:
- MAX_PULSES, 3: largest legal pulse count per request.
- CNT_W, 2: width of `pulse_cnt`; must hold MAX_PULSES.
- GAP_W, 4: width of `gap_len`.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  1  request level; only its rising edge matters.
- pulse_cnt  input  CNT_W  number of ack pulses; sampled on the accepted rise.
- gap_len  input  GAP_W  low cycles before each ack; sampled on the accepted rise.
- ack  output  1  single-cycle acknowledge pulse.
- busy  output  1  sequence in progress (states WAIT, PULSE, DONE).
- done  output  1  one-cycle pulse after the last ack.
- err  output  1  one-cycle pulse: illegal pulse_cnt on a rise.
- drop  output  1  one-cycle pulse: rise seen while busy, ignored.

Behaviour:
- Reset (asynchronous, active-low):
  - Outputs ack, busy, done, err and drop all go to 0 immediately.
  - State goes to IDLE; req_q, timer and remaining go to 0.
- Reset mid-sequence aborts the sequence; no done is produced.
- Outputs are registered.
- Rise detection:
  - `rise = req & ~req_q`, where req_q is req registered each clock.
  - A req already high at the first edge after reset counts as a rise.
- g_eff = max(gap_len, 1), so acks are always non-consecutive.
- States:
  - IDLE, rise, pulse_cnt in 1..MAX_PULSES: latch remaining=pulse_cnt and g_eff; set timer=g_eff-1; go to WAIT; busy<=1.
  - IDLE, rise, pulse_cnt==0 or >MAX_PULSES: err<=1 for one cycle; stay IDLE.
  - WAIT: if timer==0, then ack<=1 and go to PULSE; else timer<=timer-1.
  - PULSE: ack<=0; remaining<=remaining-1.
    - If remaining==1: done<=1, go to DONE.
    - Else: timer<=g_eff-1, go to WAIT.
  - DONE: done<=0, busy<=0, go to IDLE.
- Timing, with the rise sampled at edge E0:
  - First ack is high from edge E0+g_eff to edge E0+g_eff+1.
  - Each later ack is preceded by exactly g_eff low cycles.
  - done is high during the cycle immediately after the last ack.
  - Total sequence length: N*(g_eff+1)+1 cycles from E0 to busy falling.
- A rise in WAIT, PULSE or DONE produces drop<=1 for one cycle.
  - The sequence is unaffected; no queuing.
- req falling mid-sequence has no effect; the sequence always completes.
- pulse_cnt and gap_len changes after the accepted rise have no effect.
- Invariants:
  - ack and done are never high in the same cycle.
  - ack is never high on two consecutive cycles.
  - Consequently ack satisfies `ack[=N]` and `ack[->N]` within the sequence window.

Test Plan:
- Basic N=3:
  - Stimulus: pulse_cnt=3, gap_len=1, req rises, sampled at edge 2.
  - Required: ack high after edges 3, 5 and 7; done high after edge 8; busy low after edge 9.
  - Bound goto assertion `$rose(req) |-> strong(ack[->1:3])` passes.
- Single pulse, long gap:
  - Stimulus: pulse_cnt=1, gap_len=5, rise at edge E0.
  - Required: exactly one ack, at E0+5; done at E0+6; no further acks.
- Illegal count:
  - Stimulus: pulse_cnt=0 on a rise, then separately pulse_cnt=... wait, values above MAX_PULSES require CNT_W>2; with defaults use pulse_cnt=0.
  - Required: err pulses once, the cycle after the rise; no ack; busy stays 0.
- gap_len=0 and drop:
  - Stimulus: pulse_cnt=2, gap_len=0; a second rise of req during WAIT.
  - Required: acks spaced by exactly 1 low cycle; drop pulses once; only 2 acks total.
- Reset mid-sequence:
  - Stimulus: pulse_cnt=3, gap_len=2; rst_n low between clock edges after the first ack.
  - Required: ack and busy drop to 0 immediately, no done.
  - After release, a new rise starts a fresh full sequence.
- Back-to-back requests:
  - Stimulus: second rise exactly one cycle after busy falls.
  - Required: accepted with no drop; full second sequence with its newly sampled pulse_cnt and gap_len.
